tone_synth: RTL

TONE_SYNTH -- requirements
Module: tone_synth

---
 rtl/tone_pkg.sv | 33 +++
 rtl/tone_synth_pdm.sv | 33 +++
 rtl/tone_synth.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/tone_pkg.sv
// Shared types and constants for the tone synthesizer.
package tone_pkg;

    localparam int VOL_W      = 4;
    localparam int WAVE_AW    = 8;
    localparam int SAMPLE_W   = 8;
    // Storage width of the step field; the synth uses the low STEP_W bits.
    localparam int STEP_MAX_W = 16;

    typedef struct packed {
        logic [STEP_MAX_W-1:0] step;
        logic [VOL_W-1:0]      vol;
        logic                  on;
    } ch_reg_t;

    // Wavetable contents: a ramp, wave[i] = i.
    function automatic logic [SAMPLE_W-1:0] wave_lookup(input logic [WAVE_AW-1:0] idx);
        return SAMPLE_W'(idx);
    endfunction

    // Volume scaling: (sample * (vol + 1)) >> 4, or zero for a muted channel.
    function automatic logic [SAMPLE_W-1:0] scale_sample(
        input logic [SAMPLE_W-1:0] sample,
        input logic [VOL_W-1:0]    vol,
        input logic                on
    );
        logic [SAMPLE_W+VOL_W-1:0] prod;
        prod = (SAMPLE_W+VOL_W)'(sample) *
               ((SAMPLE_W+VOL_W)'(vol) + (SAMPLE_W+VOL_W)'(1));
        return on ? prod[SAMPLE_W+VOL_W-1:VOL_W] : '0;
    endfunction

endpackage

// File: rtl/tone_synth_pdm.sv
// First-order sigma-delta modulator turning an unsigned sample into a bit stream.
module pdm #(
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [DEPTH-1:0] din,
    output logic             dout
);

    logic [DEPTH:0] sd_q, sd_d;

    // Accumulate the input; the carry out is the output bit.
    always_comb begin
        sd_d = sd_q;
        if (en) begin
            sd_d = {1'b0, sd_q[DEPTH-1:0]} + {1'b0, din};
        end
    end

    // Modulator state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            sd_q <= '0;
        end else begin
            sd_q <= sd_d;
        end
    end

    assign dout = sd_q[DEPTH];

endmodule

// File: rtl/tone_synth.sv
// Multi-channel wavetable tone synthesizer with round-robin channel scan,
// three-stage pipeline (address/accumulate, ROM data, mix) and PDM output.
// Optional feature: TONE_SYNTH_UPDOWN_EN adds uptone/downtone buttons that
// nudge channel 0's phase step on their rising edges.
module tone_synth
    import tone_pkg::*;
#(
    parameter int    NCH       = 4,
    parameter int    ACC_W     = 19,
    parameter int    STEP_W    = 8,
    parameter string WAVE_FILE = "wave.mem"
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 en,
    input  logic                                 wr_en,
    input  logic [((NCH > 1) ? $clog2(NCH) : 1)-1:0] wr_ch,
    input  logic [STEP_W-1:0]                    wr_step,
    input  logic [VOL_W-1:0]                     wr_vol,
    input  logic                                 wr_on,
    input  logic                                 wr_phase_clr,
    input  logic                                 uptone,
    input  logic                                 downtone,
    output logic [SAMPLE_W-1:0]                  mix,
    output logic                                 mix_valid,
    output logic                                 pwm
);

    localparam int              CH_W    = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int              LOG_NCH = $clog2(NCH);
    localparam int              MIX_W   = SAMPLE_W + LOG_NCH;
    localparam logic [CH_W-1:0] LAST_CH = CH_W'(NCH - 1);

    // The wavetable is built in-line; the image name is kept for tooling.
    localparam string wave_file_unused = WAVE_FILE;

    logic [CH_W-1:0]     ch_cnt_q, ch_cnt_d;
    logic [ACC_W-1:0]    acc_q [NCH];
    logic [ACC_W-1:0]    acc_d [NCH];
    ch_reg_t             regs_q [NCH];
    ch_reg_t             regs_d [NCH];

    logic                p1_vld_q, p1_vld_d;
    logic [CH_W-1:0]     p1_ch_q, p1_ch_d;
    logic [VOL_W-1:0]    p1_vol_q, p1_vol_d;
    logic                p1_on_q, p1_on_d;
    logic [SAMPLE_W-1:0] rom_q, rom_d;

    logic                p2_vld_q, p2_vld_d;
    logic [CH_W-1:0]     p2_ch_q, p2_ch_d;
    logic [VOL_W-1:0]    p2_vol_q, p2_vol_d;
    logic                p2_on_q, p2_on_d;
    logic [SAMPLE_W-1:0] wave_q, wave_d;

    logic [MIX_W-1:0]    mix_acc_q, mix_acc_d;
    logic [SAMPLE_W-1:0] mix_q, mix_d;
    logic                mix_valid_q, mix_valid_d;

    logic [WAVE_AW-1:0]  rom_addr;
    logic [VOL_W-1:0]    cur_vol;
    logic                cur_on;
    logic [SAMPLE_W-1:0] term;
    logic [MIX_W-1:0]    sum;

`ifdef TONE_SYNTH_UPDOWN_EN
    logic                up_q, up_d, dn_q, dn_d;
    logic                up_rise, dn_rise;
    logic [STEP_W-1:0]   step0;
`else
    logic                btn_unused;
    assign btn_unused = uptone | downtone;
`endif

    // Select the scanned channel's phase (ROM address) and its volume/enable.
    always_comb begin
        rom_addr = '0;
        cur_vol  = '0;
        cur_on   = 1'b0;
        for (int c = 0; c < NCH; c++) begin
            if (ch_cnt_q == CH_W'(c)) begin
                rom_addr = acc_q[c][ACC_W-1 -: WAVE_AW];
                cur_vol  = regs_q[c].vol;
                cur_on   = regs_q[c].on;
            end
        end
    end

    // Scan, accumulate, pipeline advance and frame mixing.
    always_comb begin
        ch_cnt_d    = ch_cnt_q;
        for (int c = 0; c < NCH; c++) acc_d[c] = acc_q[c];
        p1_vld_d    = p1_vld_q;
        p1_ch_d     = p1_ch_q;
        p1_vol_d    = p1_vol_q;
        p1_on_d     = p1_on_q;
        rom_d       = rom_q;
        p2_vld_d    = p2_vld_q;
        p2_ch_d     = p2_ch_q;
        p2_vol_d    = p2_vol_q;
        p2_on_d     = p2_on_q;
        wave_d      = wave_q;
        mix_acc_d   = mix_acc_q;
        mix_d       = mix_q;
        mix_valid_d = 1'b0;
        term        = scale_sample(wave_q, p2_vol_q, p2_on_q);
        sum         = (p2_ch_q == '0) ? MIX_W'(term) : mix_acc_q + MIX_W'(term);

        if (en) begin
            ch_cnt_d = (ch_cnt_q == LAST_CH) ? '0 : ch_cnt_q + 1'b1;
            for (int c = 0; c < NCH; c++) begin
                if (ch_cnt_q == CH_W'(c) && regs_q[c].on) begin
                    acc_d[c] = acc_q[c] + ACC_W'(regs_q[c].step);
                end
            end
            p1_vld_d = 1'b1;
            p1_ch_d  = ch_cnt_q;
            p1_vol_d = cur_vol;
            p1_on_d  = cur_on;
            rom_d    = wave_lookup(rom_addr);
            p2_vld_d = p1_vld_q;
            p2_ch_d  = p1_ch_q;
            p2_vol_d = p1_vol_q;
            p2_on_d  = p1_on_q;
            wave_d   = rom_q;
            if (p2_vld_q) begin
                mix_acc_d = sum;
                if (p2_ch_q == LAST_CH) begin
                    mix_d       = sum[MIX_W-1:LOG_NCH];
                    mix_valid_d = 1'b1;
                end
            end
        end

        // A phase clear lands even when the scan is frozen and beats the accumulate.
        for (int c = 0; c < NCH; c++) begin
            if (wr_en && wr_phase_clr && wr_ch == CH_W'(c)) begin
                acc_d[c] = '0;
            end
        end
    end

`ifdef TONE_SYNTH_UPDOWN_EN
    // Button edge detection.
    always_comb begin
        up_d    = uptone;
        dn_d    = downtone;
        up_rise = uptone & ~up_q;
        dn_rise = downtone & ~dn_q;
        step0   = regs_q[0].step[STEP_W-1:0];
    end
`endif

    // Channel register writes; an explicit write to ch0 beats the buttons.
    always_comb begin
        for (int c = 0; c < NCH; c++) regs_d[c] = regs_q[c];
`ifdef TONE_SYNTH_UPDOWN_EN
        if (up_rise) begin
            regs_d[0].step = STEP_MAX_W'(STEP_W'(step0 + STEP_W'(1)));
        end else if (dn_rise) begin
            regs_d[0].step = STEP_MAX_W'(STEP_W'(step0 - STEP_W'(1)));
        end
`endif
        if (wr_en) begin
            for (int c = 0; c < NCH; c++) begin
                if (wr_ch == CH_W'(c)) begin
                    regs_d[c].step = STEP_MAX_W'(wr_step);
                    regs_d[c].vol  = wr_vol;
                    regs_d[c].on   = wr_on;
                end
            end
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            ch_cnt_q <= '0;
            for (int c = 0; c < NCH; c++) begin
                acc_q[c]       <= '0;
                regs_q[c].step <= (c == 0) ? STEP_MAX_W'(8) : '0;
                regs_q[c].vol  <= (c == 0) ? '1 : '0;
                regs_q[c].on   <= (c == 0);
            end
            p1_vld_q    <= 1'b0;
            p1_ch_q     <= '0;
            p1_vol_q    <= '0;
            p1_on_q     <= 1'b0;
            rom_q       <= '0;
            p2_vld_q    <= 1'b0;
            p2_ch_q     <= '0;
            p2_vol_q    <= '0;
            p2_on_q     <= 1'b0;
            wave_q      <= '0;
            mix_acc_q   <= '0;
            mix_q       <= '0;
            mix_valid_q <= 1'b0;
`ifdef TONE_SYNTH_UPDOWN_EN
            up_q        <= 1'b0;
            dn_q        <= 1'b0;
`endif
        end else begin
            ch_cnt_q <= ch_cnt_d;
            for (int c = 0; c < NCH; c++) begin
                acc_q[c]  <= acc_d[c];
                regs_q[c] <= regs_d[c];
            end
            p1_vld_q    <= p1_vld_d;
            p1_ch_q     <= p1_ch_d;
            p1_vol_q    <= p1_vol_d;
            p1_on_q     <= p1_on_d;
            rom_q       <= rom_d;
            p2_vld_q    <= p2_vld_d;
            p2_ch_q     <= p2_ch_d;
            p2_vol_q    <= p2_vol_d;
            p2_on_q     <= p2_on_d;
            wave_q      <= wave_d;
            mix_acc_q   <= mix_acc_d;
            mix_q       <= mix_d;
            mix_valid_q <= mix_valid_d;
`ifdef TONE_SYNTH_UPDOWN_EN
            up_q        <= up_d;
            dn_q        <= dn_d;
`endif
        end
    end

    assign mix       = mix_q;
    assign mix_valid = mix_valid_q;

    pdm #(.DEPTH(8)) u_pdm (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .din  (mix_q),
        .dout (pwm)
    );

endmodule
